// File: rtl/mul_arbiter_pkg.sv
// Shared definitions for the multiplier arbitration front-end: FSM states,
// data/ID widths and the hold-counter load helper.
package mul_arbiter_pkg;

    localparam int REQ_ID_W           = 1;
    localparam int DATA_W             = 16;
    localparam int MUL_CYCLES_DEFAULT = 2;
    localparam int CNT_W              = 4;
    localparam int NUM_REQ            = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Value loaded into the hold counter on acceptance. The product is
    // captured when the counter reaches zero, so the operands are held for
    // exactly 'cycles' clock periods. Out-of-range settings are clamped to
    // the 1..15 range the counter can express.
    function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
        int v;
        v = cycles - 1;
        if (v < 0) begin
            v = 0;
        end
        if (v > 14) begin
            v = 14;
        end
        return CNT_W'(v);
    endfunction

endpackage

// File: rtl/mul_arbiter_multiplier.sv
// Shared 16x16 unsigned combinational multiplier. Built as a shift-and-add
// ripple of partial products; the full path is long and is expected to be
// timed as a multicycle path by the surrounding sequencer.
module multiplier
    import mul_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] l_m,
    output logic [DATA_W-1:0] r_m
);

    logic [2*DATA_W-1:0] pp [DATA_W];
    logic [2*DATA_W-1:0] product;

    // One partial product per multiplier bit: a shifted into place, or zero.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pp
            assign pp[gi] = b[gi] ? ({{DATA_W{1'b0}}, a} << gi) : '0;
        end
    endgenerate

    // Ripple accumulation of the partial products into the 32-bit product.
    always_comb begin
        product = '0;
        for (int i = 0; i < DATA_W; i++) begin
            product = product + pp[i];
        end
    end

    assign l_m = product[DATA_W-1:0];
    assign r_m = product[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin front-end for the shared multiplier. Two requesters compete
// for the multiplier; the winner's operands are latched and held steady for
// MUL_CYCLES cycles, then the product is registered and returned on a single
// tagged response channel that honours backpressure.
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    input  logic [DATA_W-1:0]   req0_a,
    input  logic [DATA_W-1:0]   req0_b,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [DATA_W-1:0]   req1_a,
    input  logic [DATA_W-1:0]   req1_b,
    output logic                req1_ready,
    output logic                resp_valid,
    output logic [REQ_ID_W-1:0] resp_id,
    output logic [DATA_W-1:0]   resp_lo,
    output logic [DATA_W-1:0]   resp_hi,
    input  logic                resp_ready,
    output logic                busy
);

    state_t              state_reg,      state_next;
    logic [CNT_W-1:0]    cnt_reg,        cnt_next;
    logic [REQ_ID_W-1:0] last_grant_reg, last_grant_next;
    logic [REQ_ID_W-1:0] id_reg,         id_next;
    logic [DATA_W-1:0]   op_a_reg,       op_a_next;
    logic [DATA_W-1:0]   op_b_reg,       op_b_next;
    logic [REQ_ID_W-1:0] resp_id_reg,    resp_id_next;
    logic [DATA_W-1:0]   res_lo_reg,     res_lo_next;
    logic [DATA_W-1:0]   res_hi_reg,     res_hi_next;

    logic                grant_valid;
    logic [REQ_ID_W-1:0] grant_id;
    logic                can_accept;
    logic [NUM_REQ-1:0]  ready_vec;
    logic [NUM_REQ-1:0]  valid_vec;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [DATA_W-1:0]   prod_lo;
    logic [DATA_W-1:0]   prod_hi;

    assign valid_vec = {req1_valid, req0_valid};

    // Round-robin choice: a lone requester wins outright; under contention
    // the requester that was not served last time wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        if (req0_valid && req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = ~last_grant_reg;
        end else if (req0_valid) begin
            grant_valid = 1'b1;
            grant_id    = REQ_ID_W'(0);
        end else if (req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = REQ_ID_W'(1);
        end
    end

    // Requests are only taken in IDLE and never while reset is asserted.
    assign can_accept = (state_reg == IDLE) && !rst && grant_valid;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign ready_vec[gi] = can_accept && (grant_id == REQ_ID_W'(gi));
        end
    endgenerate

    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];

    // Operand mux feeding the op registers; only sampled on a transfer.
    assign sel_a = (grant_id == REQ_ID_W'(1)) ? req1_a : req0_a;
    assign sel_b = (grant_id == REQ_ID_W'(1)) ? req1_b : req0_b;

    // The multiplier sees only the op registers, which are frozen in CALC.
    multiplier u_mul (
        .a   (op_a_reg),
        .b   (op_b_reg),
        .l_m (prod_lo),
        .r_m (prod_hi)
    );

    // Next-state and datapath-load decisions for the accept/hold/respond cycle.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        last_grant_next = last_grant_reg;
        id_next         = id_reg;
        op_a_next       = op_a_reg;
        op_b_next       = op_b_reg;
        resp_id_next    = resp_id_reg;
        res_lo_next     = res_lo_reg;
        res_hi_next     = res_hi_reg;

        case (state_reg)
            IDLE: begin
                if ((ready_vec & valid_vec) != '0) begin
                    op_a_next       = sel_a;
                    op_b_next       = sel_b;
                    id_next         = grant_id;
                    last_grant_next = grant_id;
                    cnt_next        = cnt_load(MUL_CYCLES);
                    state_next      = CALC;
                end
            end
            CALC: begin
                if (cnt_reg == '0) begin
                    res_lo_next  = prod_lo;
                    res_hi_next  = prod_hi;
                    resp_id_next = id_reg;
                    state_next   = DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; an in-flight
    // operation is simply dropped when reset arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            last_grant_reg <= REQ_ID_W'(1);
            id_reg         <= '0;
            op_a_reg       <= '0;
            op_b_reg       <= '0;
            resp_id_reg    <= '0;
            res_lo_reg     <= '0;
            res_hi_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            last_grant_reg <= last_grant_next;
            id_reg         <= id_next;
            op_a_reg       <= op_a_next;
            op_b_reg       <= op_b_next;
            resp_id_reg    <= resp_id_next;
            res_lo_reg     <= res_lo_next;
            res_hi_reg     <= res_hi_next;
        end
    end

    assign resp_valid = (state_reg == DONE);
    assign resp_id    = resp_id_reg;
    assign resp_lo    = res_lo_reg;
    assign resp_hi    = res_hi_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter. Three instances (MUL_CYCLES = 1, 2, 4)
// share the same stimulus; the MUL_CYCLES = 2 instance (index 1) carries the
// contention, backpressure and arbitration scenarios.
module tb_mul_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic        req1_valid;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic        resp_ready;

    logic        r0_rdy [3];
    logic        r1_rdy [3];
    logic        rv     [3];
    logic        rid    [3];
    logic        bsy    [3];
    logic [15:0] rlo    [3];
    logic [15:0] rhi    [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_arbiter #(.MUL_CYCLES(1)) u_dut_m1 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(r0_rdy[0]),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(r1_rdy[0]),
        .resp_valid(rv[0]), .resp_id(rid[0]), .resp_lo(rlo[0]), .resp_hi(rhi[0]),
        .resp_ready(resp_ready), .busy(bsy[0])
    );

    mul_arbiter #(.MUL_CYCLES(2)) u_dut_m2 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(r0_rdy[1]),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(r1_rdy[1]),
        .resp_valid(rv[1]), .resp_id(rid[1]), .resp_lo(rlo[1]), .resp_hi(rhi[1]),
        .resp_ready(resp_ready), .busy(bsy[1])
    );

    mul_arbiter #(.MUL_CYCLES(4)) u_dut_m4 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(r0_rdy[2]),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(r1_rdy[2]),
        .resp_valid(rv[2]), .resp_id(rid[2]), .resp_lo(rlo[2]), .resp_hi(rhi[2]),
        .resp_ready(resp_ready), .busy(bsy[2])
    );

    // Accept-to-resp_valid latency (MUL_CYCLES + 1) per instance.
    function automatic int lat_of(input int d);
        case (d)
            0:       return 2;
            1:       return 3;
            default: return 5;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        resp_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One request on all instances at once, then exact-latency and payload
    // checks on each; optionally scrambles the operand inputs after accept.
    task automatic single_req(input string tag, input logic id, input logic [15:0] a,
                              input logic [15:0] b, input logic [15:0] exp_lo,
                              input logic [15:0] exp_hi, input logic corrupt);
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            chk({tag, "_rdy0"}, r0_rdy[d], (id == 1'b0));
            chk({tag, "_rdy1"}, r1_rdy[d], (id == 1'b1));
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (corrupt) begin
            req0_a = 16'hFFFF; req0_b = 16'hFFFF;
            req1_a = 16'hFFFF; req1_b = 16'hFFFF;
        end
        for (int k = 1; k <= 6; k++) begin
            for (int d = 0; d < 3; d++) begin
                chk({tag, "_valid"}, rv[d], (k == lat_of(d)));
                chk({tag, "_busy"}, bsy[d], (k <= lat_of(d)));
                if (k == lat_of(d)) begin
                    $display("%s dut=%0d cycle=%0d id=%0d hi=0x%04h lo=0x%04h",
                             tag, d, k, rid[d], rhi[d], rlo[d]);
                    chk({tag, "_id"}, rid[d], id);
                    chk({tag, "_lo"}, rlo[d], exp_lo);
                    chk({tag, "_hi"}, rhi[d], exp_hi);
                end
            end
            @(negedge clk);
        end
    endtask

    // Contention on instance 1: grants alternate 0,1,0,1 at the minimum interval.
    task automatic contention_test();
        int  n;
        int  last_cyc;
        logic exp_id;
        n = 0;
        last_cyc = 0;
        exp_id = 1'b0;
        req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h0010;
        req1_valid = 1'b1; req1_a = 16'h0100; req1_b = 16'h0007;
        #1;
        chk("cont_first_rdy0", r0_rdy[1], 1'b1);
        chk("cont_first_rdy1", r1_rdy[1], 1'b0);
        for (int cyc = 1; cyc <= 40 && n < 4; cyc++) begin
            @(negedge clk);
            if (rv[1]) begin
                $display("contention resp n=%0d cycle=%0d id=%0d hi=0x%04h lo=0x%04h",
                         n, cyc, rid[1], rhi[1], rlo[1]);
                chk("cont_id", rid[1], exp_id);
                chk("cont_lo", rlo[1], (exp_id == 1'b0) ? 16'h2340 : 16'h0700);
                chk("cont_hi", rhi[1], (exp_id == 1'b0) ? 16'h0001 : 16'h0000);
                if (n == 0) begin
                    chk("cont_latency", cyc, 3);
                end else begin
                    chk("cont_interval", cyc - last_cyc, 4);
                end
                last_cyc = cyc;
                exp_id = ~exp_id;
                n++;
            end
        end
        chk("cont_count", n, 4);
        idle_inputs();
    endtask

    // Backpressure on instance 1: response held for 5 cycles, nothing accepted.
    task automatic backpressure_test();
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 16'h0007; req0_b = 16'h0009;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 16'h0002; req1_b = 16'h0003;
        for (int c = 0; c < 10 && !rv[1]; c++) begin
            @(negedge clk);
        end
        chk("bp_resp_seen", rv[1], 1'b1);
        for (int k = 0; k < 5; k++) begin
            $display("backpressure hold k=%0d valid=%0d hi=0x%04h lo=0x%04h",
                     k, rv[1], rhi[1], rlo[1]);
            chk("bp_valid", rv[1], 1'b1);
            chk("bp_id", rid[1], 1'b0);
            chk("bp_lo", rlo[1], 16'h003F);
            chk("bp_hi", rhi[1], 16'h0000);
            chk("bp_rdy0", r0_rdy[1], 1'b0);
            chk("bp_rdy1", r1_rdy[1], 1'b0);
            chk("bp_busy", bsy[1], 1'b1);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_release_rdy1", r1_rdy[1], 1'b0);
        @(negedge clk);
        chk("bp_after_valid", rv[1], 1'b0);
        chk("bp_after_busy", bsy[1], 1'b0);
        chk("bp_after_rdy1", r1_rdy[1], 1'b1);
        idle_inputs();
    endtask

    // Reset in CALC drops the operation; first post-reset contention goes to 0.
    task automatic reset_midop_test();
        req0_valid = 1'b1; req0_a = 16'h00AB; req0_b = 16'h00CD;
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1; req1_a = 16'h0011; req1_b = 16'h0022;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_rdy0", r0_rdy[d], 1'b0);
            chk("rst_rdy1", r1_rdy[d], 1'b0);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk("rst_valid", rv[d], 1'b0);
                chk("rst_busy", bsy[d], 1'b0);
                chk("rst_lo", rlo[d], 16'h0000);
                chk("rst_hi", rhi[d], 16'h0000);
                chk("rst_id", rid[d], 1'b0);
            end
        end
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            $display("post-reset contention dut=%0d rdy0=%0d rdy1=%0d", d, r0_rdy[d], r1_rdy[d]);
            chk("post_rst_rdy0", r0_rdy[d], 1'b1);
            chk("post_rst_rdy1", r1_rdy[d], 1'b0);
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset_valid", rv[d], 1'b0);
            chk("reset_id", rid[d], 1'b0);
            chk("reset_lo", rlo[d], 16'h0000);
            chk("reset_hi", rhi[d], 16'h0000);
            chk("reset_busy", bsy[d], 1'b0);
            chk("reset_rdy0", r0_rdy[d], 1'b0);
            chk("reset_rdy1", r1_rdy[d], 1'b0);
        end
        do_reset();

        single_req("single", 1'b0, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 1'b0);
        single_req("maxop", 1'b1, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0);
        single_req("corrupt_a", 1'b0, 16'h00C8, 16'h0064, 16'h4E20, 16'h0000, 1'b1);
        single_req("corrupt_b", 1'b0, 16'h8001, 16'h0003, 16'h8003, 16'h0001, 1'b1);

        do_reset();
        contention_test();
        do_reset();
        backpressure_test();
        do_reset();
        reset_midop_test();
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
